// File: rtl/sort_pipe_pkg.sv
// ---------------------------------------------------------------------------
// sort_pipe_pkg
//   Constants and FSM state encoding shared by the stages of the
//   sort / dedup / successive-difference pipeline.
//
//   DATA_W  width of one element and of one serialized output byte
//   MAX_N   number of elements carried in one parallel frame
//   CNT_W   width of an element count; 2**CNT_W must exceed MAX_N
// ---------------------------------------------------------------------------
package sort_pipe_pkg;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 9;
    localparam int CNT_W  = 4;

    // ST_CSUM is only reachable in builds that append a checksum byte
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_CSUM = 2'd3
    } state_e;

endpackage

// File: rtl/delta_csum_acc.sv
// ---------------------------------------------------------------------------
// delta_csum_acc
//   Running modulo-2**DATA_W sum of every byte that leaves the serializer.
//   The module exists only when SUM_CHECKSUM_EN is defined; the default
//   build has no checksum hardware at all.
//
//   clk_i    rising-edge clock
//   rst_n_i  synchronous active-low reset
//   clear_i  restart the sum (asserted when a new frame is captured)
//   add_i    accumulate data_i (asserted on every output handshake)
//   data_i   byte being transferred
//   sum_o    sum of all bytes accumulated since the last clear
// ---------------------------------------------------------------------------
`ifdef SUM_CHECKSUM_EN
module delta_csum_acc #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] sum_o
);

    logic [DATA_W-1:0] acc_q;

    // Clear takes priority; a frame is only captured while nothing is
    // being transferred, so the two never collide in practice
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= acc_q + data_i;
        end
    end

    assign sum_o = acc_q;

endmodule
`endif

// File: rtl/delta_frame_serializer.sv
// ---------------------------------------------------------------------------
// delta_frame_serializer
//   Captures one parallel frame (MAX_N delta bytes plus a unique count) and
//   streams it out byte-serially over a valid/ready link: a header byte
//   holding the clamped count, then that many delta bytes. Elements beyond
//   the count are never sent.
//
//   Build option SUM_CHECKSUM_EN: append a trailing byte carrying the
//   modulo-2**DATA_W sum of the header and body bytes; m_last then marks
//   that byte instead of the header or final element.
//
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   frame_valid  parallel frame presented by upstream
//   frame_ready  serializer idle and able to take a frame
//   frame_data   element k (1-based) at [k*DATA_W-1 -: DATA_W]
//   frame_count  number of valid leading elements
//   m_valid      output byte valid
//   m_ready      downstream accepts the byte
//   m_data       output byte
//   m_last       final byte of the frame
//   count_err    sticky flag: a frame arrived with frame_count > MAX_N
// ---------------------------------------------------------------------------
module delta_frame_serializer #(
    parameter int DATA_W = sort_pipe_pkg::DATA_W,
    parameter int MAX_N  = sort_pipe_pkg::MAX_N,
    parameter int CNT_W  = sort_pipe_pkg::CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [MAX_N*DATA_W-1:0] frame_data,
    input  logic [CNT_W-1:0]        frame_count,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic                    count_err
);

    import sort_pipe_pkg::*;

    state_e                  state_q;
    logic [MAX_N*DATA_W-1:0] frameData_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        index_q;
    logic                    frameReady_q;
    logic                    mValid_q;
    logic [DATA_W-1:0]       mData_q;
    logic                    mLast_q;
    logic                    countErr_q;

    logic                    capture_d;
    logic                    xfer_d;
    logic                    overCount_d;
    logic [CNT_W-1:0]        clampedCount_d;
    logic [CNT_W-1:0]        selIndex_d;
    logic [DATA_W-1:0]       selElem_d;
    logic                    lastBody_d;

    assign capture_d   = frame_valid && frameReady_q;
    assign xfer_d      = mValid_q && m_ready;
    assign overCount_d = (frame_count > CNT_W'(MAX_N));

    // Counts above MAX_N are clamped so the body never indexes past the
    // captured frame
    always_comb begin
        clampedCount_d = frame_count;
        if (overCount_d) begin
            clampedCount_d = CNT_W'(MAX_N);
        end
    end

    // The byte following the one now on the link: element 1 after the
    // header, otherwise the next element. lastBody_d says the byte now on
    // the link is the final header/body byte of the frame.
    always_comb begin
        selIndex_d = index_q + CNT_W'(1);
        lastBody_d = (index_q == count_q);
        if (state_q == ST_HDR) begin
            selIndex_d = CNT_W'(1);
            lastBody_d = (count_q == '0);
        end
    end

    // Element select on the registered frame; element 1 sits in the LSBs
    always_comb begin
        selElem_d = '0;
        for (int k = 1; k <= MAX_N; k++) begin
            if (selIndex_d == CNT_W'(k)) begin
                selElem_d = frameData_q[k*DATA_W-1 -: DATA_W];
            end
        end
    end

`ifdef SUM_CHECKSUM_EN
    logic [DATA_W-1:0] csumSum;
    logic [DATA_W-1:0] csumByte_d;

    delta_csum_acc #(
        .DATA_W (DATA_W)
    ) u_csum (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .clear_i (capture_d),
        .add_i   (xfer_d),
        .data_i  (mData_q),
        .sum_o   (csumSum)
    );

    // The accumulator has not yet seen the byte currently on the link,
    // so fold it in when forming the checksum byte
    assign csumByte_d = csumSum + mData_q;
`endif

    // Frame FSM with registered outputs: each handshake loads the next
    // byte and its last flag, so m_data/m_last stay put while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            frameData_q  <= '0;
            count_q      <= '0;
            index_q      <= '0;
            frameReady_q <= 1'b1;
            mValid_q     <= 1'b0;
            mData_q      <= '0;
            mLast_q      <= 1'b0;
            countErr_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (capture_d) begin
                        frameData_q  <= frame_data;
                        count_q      <= clampedCount_d;
                        index_q      <= '0;
                        frameReady_q <= 1'b0;
                        mValid_q     <= 1'b1;
                        mData_q      <= DATA_W'(clampedCount_d);
`ifdef SUM_CHECKSUM_EN
                        mLast_q      <= 1'b0;
`else
                        mLast_q      <= (clampedCount_d == '0);
`endif
                        state_q      <= ST_HDR;
                        if (overCount_d) begin
                            countErr_q <= 1'b1;
                        end
                    end
                end
                ST_HDR, ST_BODY: begin
                    if (xfer_d) begin
                        if (lastBody_d) begin
`ifdef SUM_CHECKSUM_EN
                            mData_q      <= csumByte_d;
                            mLast_q      <= 1'b1;
                            state_q      <= ST_CSUM;
`else
                            mValid_q     <= 1'b0;
                            mData_q      <= '0;
                            mLast_q      <= 1'b0;
                            index_q      <= '0;
                            frameReady_q <= 1'b1;
                            state_q      <= ST_IDLE;
`endif
                        end else begin
                            index_q <= selIndex_d;
                            mData_q <= selElem_d;
`ifdef SUM_CHECKSUM_EN
                            mLast_q <= 1'b0;
`else
                            mLast_q <= (selIndex_d == count_q);
`endif
                            state_q <= ST_BODY;
                        end
                    end
                end
`ifdef SUM_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer_d) begin
                        mValid_q     <= 1'b0;
                        mData_q      <= '0;
                        mLast_q      <= 1'b0;
                        index_q      <= '0;
                        frameReady_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_ready = frameReady_q;
    assign m_valid     = mValid_q;
    assign m_data      = mData_q;
    assign m_last      = mLast_q;
    assign count_err   = countErr_q;

endmodule
